hsmc_tx_phase_sequencer: RTL

//   Sequences the HSMC LVDS TX pairs for link bring-up. Fetches one LANES-wide word per frame over a

---
 rtl/hsmc_tx_phase_sequencer_pkg.sv | 29 ++
 rtl/hsmc_tx_phase_sequencer_if.sv | 26 ++
 rtl/hsmc_tx_phase_sequencer_dwell_timer.sv | 26 ++
 rtl/hsmc_tx_phase_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/hsmc_tx_phase_sequencer_pkg.sv
// Shared types, phase encodings and width helpers for the HSMC TX phase sequencer.
package hsmc_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRIVE_P,
    ST_GUARD_P,
    ST_DRIVE_N,
    ST_GUARD_N,
    ST_DONE
  } state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_IDLE  = 2'd0;
  localparam phase_t PH_P     = 2'd1;
  localparam phase_t PH_GUARD = 2'd2;
  localparam phase_t PH_N     = 2'd3;

  function automatic int dwell_width(input int shift);
    return 4 + shift;
  endfunction

  function automatic int guard_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/hsmc_tx_phase_sequencer_if.sv
// Pattern-source handshake plus TX pin / status bundle of the HSMC TX phase sequencer.
interface hsmc_tx_phase_sequencer_if
  import hsmc_tx_pkg::*;
#(
  parameter int LANES = 4
);
  logic             EN;
  logic [3:0]       DWELL;
  logic [LANES-1:0] DATA;
  logic             DATA_VALID;
  logic             DATA_READY;
  logic [LANES-1:0] TX_P;
  logic [LANES-1:0] TX_N;
  phase_t           PHASE;
  logic             FRAME_DONE;

  modport master (
    output EN, DWELL, DATA, DATA_VALID,
    input  DATA_READY, TX_P, TX_N, PHASE, FRAME_DONE
  );

  modport slave (
    input  EN, DWELL, DATA, DATA_VALID,
    output DATA_READY, TX_P, TX_N, PHASE, FRAME_DONE
  );
endinterface

// File: rtl/hsmc_tx_phase_sequencer_dwell_timer.sv
// Loadable down-counter that parks at zero; used for both the dwell and guard intervals.
module hsmc_dwell_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  // A load wins over a decrement; the count never wraps below zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/hsmc_tx_phase_sequencer.sv
// Fetches one word per frame and drives it on TX_P then TX_N, separated by all-zero guard gaps.
//
// state   | meaning
// IDLE    | outputs zero, waiting for EN
// LOAD    | DATA_READY high, waiting for a word
// DRIVE_P | word on TX_P for (DWELL << DWELL_SHIFT) + 1 cycles
// GUARD_P | all-zero gap, GUARD_CYCLES cycles
// DRIVE_N | word on TX_N, same dwell rule, DWELL resampled on entry
// GUARD_N | all-zero gap, GUARD_CYCLES cycles
// DONE    | one-cycle FRAME_DONE pulse
module hsmc_tx_phase_sequencer
  import hsmc_tx_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int DWELL_SHIFT  = 20,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                   OSC_50_B8A,
  input  logic                   RESET,
  hsmc_tx_phase_sequencer_if.slave bus
);
  localparam int DW = dwell_width(DWELL_SHIFT);
  localparam int GW = guard_width(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  logic             r_rst_meta, r_rst_sync;
  state_t           r_state;
  logic [LANES-1:0] r_word, r_tx_p, r_tx_n;
  phase_t           r_phase;
  logic             r_ready, r_done;

  logic          w_hs, w_dw_load, w_dw_dec, w_dw_zero, w_gd_load, w_gd_dec, w_gd_zero;
  logic [DW-1:0] w_dw_val;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge OSC_50_B8A or posedge RESET) begin
    if (RESET) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_hs      = r_ready && bus.DATA_VALID;
  assign w_dw_val  = DW'(bus.DWELL) << DWELL_SHIFT;
  assign w_dw_load = w_hs || ((r_state == ST_GUARD_P) && w_gd_zero);
  assign w_dw_dec  = (r_state == ST_DRIVE_P) || (r_state == ST_DRIVE_N);
  assign w_gd_load = w_dw_dec && w_dw_zero;
  assign w_gd_dec  = (r_state == ST_GUARD_P) || (r_state == ST_GUARD_N);

  hsmc_dwell_timer #(.W(DW)) u_dwell (
    .i_clk      (OSC_50_B8A),
    .i_rst      (r_rst_sync),
    .i_load     (w_dw_load),
    .i_load_val (w_dw_val),
    .i_dec      (w_dw_dec),
    .o_zero     (w_dw_zero)
  );

  hsmc_dwell_timer #(.W(GW)) u_guard (
    .i_clk      (OSC_50_B8A),
    .i_rst      (r_rst_sync),
    .i_load     (w_gd_load),
    .i_load_val (GUARD_LOAD),
    .i_dec      (w_gd_dec),
    .o_zero     (w_gd_zero)
  );

  // Outputs are set on the edge that enters each state, so they line up with r_state.
  always_ff @(posedge OSC_50_B8A or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_tx_p  <= '0;
      r_tx_n  <= '0;
      r_phase <= PH_IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.EN) begin
            r_state <= ST_LOAD;
            r_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_hs) begin
            r_state <= ST_DRIVE_P;
            r_word  <= bus.DATA;
            r_tx_p  <= bus.DATA;
            r_phase <= PH_P;
            r_ready <= 1'b0;
          end else if (!bus.EN) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
          end
        end
        ST_DRIVE_P: begin
          if (w_dw_zero) begin
            r_state <= ST_GUARD_P;
            r_tx_p  <= '0;
            r_phase <= PH_GUARD;
          end
        end
        ST_GUARD_P: begin
          if (w_gd_zero) begin
            r_state <= ST_DRIVE_N;
            r_tx_n  <= r_word;
            r_phase <= PH_N;
          end
        end
        ST_DRIVE_N: begin
          if (w_dw_zero) begin
            r_state <= ST_GUARD_N;
            r_tx_n  <= '0;
            r_phase <= PH_GUARD;
          end
        end
        ST_GUARD_N: begin
          if (w_gd_zero) begin
            r_state <= ST_DONE;
            r_phase <= PH_IDLE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= bus.EN ? ST_LOAD : ST_IDLE;
          r_ready <= bus.EN;
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx_p  <= '0;
          r_tx_n  <= '0;
          r_phase <= PH_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DATA_READY = r_ready;
  assign bus.TX_P       = r_tx_p;
  assign bus.TX_N       = r_tx_n;
  assign bus.PHASE      = r_phase;
  assign bus.FRAME_DONE = r_done;
endmodule
